// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - four-phase register-file ALU instruction sequencer
module reg_alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs0,
    input  logic [ADDR_W-1:0] instr_rs1,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [DATA_W-1:0] rf_rd0_data,
    input  logic [DATA_W-1:0] rf_rd1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr0_addr,
    output logic [DATA_W-1:0] rf_wr0_data,
    output logic              result_valid,
    output logic              op_err,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd0_addr_q, rd0_addr_d;
    logic [ADDR_W-1:0]   rd1_addr_q, rd1_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                carry_q, carry_d;
    logic                res_valid_q, res_valid_d;
    logic                err_q, err_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;

    logic [DATA_W:0]     alu_sum;
    logic [DATA_W:0]     alu_diff;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_defined;

    // ALU over the operands returned by the register file during EXEC
    always_comb begin
        alu_sum     = {1'b0, rf_rd0_data} + {1'b0, rf_rd1_data};
        alu_diff    = {1'b0, rf_rd0_data} - {1'b0, rf_rd1_data};
        alu_result  = '0;
        alu_carry   = 1'b0;
        alu_defined = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_result = alu_sum[DATA_W-1:0];
                alu_carry  = alu_sum[DATA_W];
            end
            OP_SUB: begin
                // the borrow out of the extended subtraction is exactly A<B
                alu_result = alu_diff[DATA_W-1:0];
                alu_carry  = alu_diff[DATA_W];
            end
            OP_AND:  alu_result = rf_rd0_data & rf_rd1_data;
            OP_OR:   alu_result = rf_rd0_data | rf_rd1_data;
            OP_XOR:  alu_result = rf_rd0_data ^ rf_rd1_data;
            OP_SHL:  alu_result = rf_rd0_data << rf_rd1_data[3:0];
            OP_SHR:  alu_result = rf_rd0_data >> rf_rd1_data[3:0];
            OP_MOV:  alu_result = rf_rd0_data;
            default: alu_defined = 1'b0;
        endcase
    end

    // next-state and next-output computation; outputs are registered so they line up with the state
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rd_en_d     = 1'b0;
        rd0_addr_d  = rd0_addr_q;
        rd1_addr_d  = rd1_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        carry_d     = carry_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d       = instr_op;
                    rd_d       = instr_rd;
                    rd0_addr_d = instr_rs0;
                    rd1_addr_d = instr_rs1;
                    rd_en_d    = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WRITE;
                if (alu_defined) begin
                    wr_en_d     = 1'b1;
                    res_valid_d = 1'b1;
                    wr_addr_d   = rd_q;
                    wr_data_d   = alu_result;
                    carry_d     = alu_carry;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                // flags commit at the end of the write cycle, only for a real write
                if (wr_en_q) begin
                    flag_z_d = (wr_data_q == '0);
                    flag_c_d = carry_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // single state/output register bank, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            rd0_addr_q  <= '0;
            rd1_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rd_en_q     <= rd_en_d;
            rd0_addr_q  <= rd0_addr_d;
            rd1_addr_q  <= rd1_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
        end
    end

    // ready is gated by rst_n so it is low during reset and high right after release
    assign instr_ready  = rst_n & (state_q == S_IDLE);
    assign rf_rd_en     = rd_en_q;
    assign rf_rd0_addr  = rd0_addr_q;
    assign rf_rd1_addr  = rd1_addr_q;
    assign rf_wr_en     = wr_en_q;
    assign rf_wr0_addr  = wr_addr_q;
    assign rf_wr0_data  = wr_data_q;
    assign result_valid = res_valid_q;
    assign op_err       = err_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - self-checking bench for reg_alu_sequencer
module tb_reg_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_rs0;
    logic [3:0]  instr_rs1;
    logic        rf_rd_en;
    logic [3:0]  rf_rd0_addr;
    logic [3:0]  rf_rd1_addr;
    logic [15:0] rf_rd0_data;
    logic [15:0] rf_rd1_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr0_addr;
    logic [15:0] rf_wr0_data;
    logic        result_valid;
    logic        op_err;
    logic        flag_z;
    logic        flag_c;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [16];
    logic [15:0] mreg [16];
    logic        mz, mc;

    typedef struct {
        logic        init;
        logic [3:0]  ra;
        logic [15:0] va;
        logic [3:0]  rb;
        logic [15:0] vb;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs0;
        logic [3:0]  rs1;
        logic [15:0] data;
        logic        z;
        logic        c;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    reg_alu_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
        .rf_rd_en(rf_rd_en), .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
        .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
        .rf_wr_en(rf_wr_en), .rf_wr0_addr(rf_wr0_addr), .rf_wr0_data(rf_wr0_data),
        .result_valid(result_valid), .op_err(op_err),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file with registered reads
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd0_data <= rf_mem[rf_rd0_addr];
            rf_rd1_data <= rf_mem[rf_rd1_addr];
        end
        if (rf_wr_en) rf_mem[rf_wr0_addr] <= rf_wr0_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output logic [15:0] r, output logic c, output logic err);
        int s;
        err = 1'b0;
        c   = 1'b0;
        r   = 16'h0;
        case (op)
            0: begin s = a + b; r = 16'(s % 65536); c = (s > 65535); end
            1: begin r = 16'((a - b + 65536) % 65536); c = (a < b); end
            2: r = 16'(a & b);
            3: r = 16'(a | b);
            4: r = 16'(a ^ b);
            5: r = 16'((a * (1 << (b % 16))) % 65536);
            6: r = 16'(a / (1 << (b % 16)));
            7: r = 16'(a);
            default: err = 1'b1;
        endcase
    endfunction

    task automatic preload(input logic [3:0] r, input logic [15:0] v);
        mreg[r]   = v;
        rf_mem[r] = v;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs0, input logic [3:0] rs1,
                             input logic [15:0] exp_data, input logic exp_z,
                             input logic exp_c, input logic exp_err);
        logic oz, oc;
        int k;
        oz = mz;
        oc = mc;
        k = 0;
        while (!instr_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs0 = rs0; instr_rs1 = rs1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = 4'($urandom); instr_rd = 4'($urandom);
        instr_rs0 = 4'($urandom); instr_rs1 = 4'($urandom);
        chk("read_en", 32'(rf_rd_en), 32'd1);
        chk("read_addr", 32'({rf_rd0_addr, rf_rd1_addr}), 32'({rs0, rs1}));
        chk("busy_read", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("exec_rd_en", 32'(rf_rd_en), 32'd0);
        chk("exec_addr_hold", 32'({rf_rd0_addr, rf_rd1_addr}), 32'({rs0, rs1}));
        chk("exec_strobes", 32'({rf_wr_en, result_valid, op_err, instr_ready}), 32'd0);
        @(negedge clk);
        chk("write_strobes", 32'({rf_wr_en, result_valid, op_err}), 32'({!exp_err, !exp_err, exp_err}));
        if (!exp_err) chk("write_addr_data", 32'({rf_wr0_addr, rf_wr0_data}), 32'({rd, exp_data}));
        chk("flags_before", 32'({flag_z, flag_c}), 32'({oz, oc}));
        @(negedge clk);
        chk("idle_strobes", 32'({rf_wr_en, result_valid, op_err, instr_ready}), 32'b0001);
        chk("flags_after", 32'({flag_z, flag_c}), 32'({exp_z, exp_c}));
        if (!exp_err) mreg[rd] = exp_data;
        mz = exp_z;
        mc = exp_c;
    endtask

    task automatic run_random(input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] rs0, input logic [3:0] rs1);
        logic [15:0] r;
        logic c, err;
        model(int'(op), int'(mreg[rs0]), int'(mreg[rs1]), r, c, err);
        run_instr(op, rd, rs0, rs1, r, err ? mz : (r == 16'h0), err ? mc : c, err);
    endtask

    initial begin
        int cnt, last;
        logic [3:0] rop;
        vecs[0]  = '{1'b1, 4'd1, 16'h0005, 4'd2, 16'h0003, 4'd0, 4'd3, 4'd1, 4'd2, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 16'hFFFF, 4'd2, 16'h0001, 4'd0, 4'd3, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'd1, 16'h0002, 4'd2, 16'h0005, 4'd1, 4'd3, 4'd1, 4'd2, 16'hFFFD, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd9, 4'd3, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 4'd4, 16'h0001, 4'd5, 16'h000F, 4'd5, 4'd4, 4'd4, 4'd5, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd7, 4'd6, 4'd4, 4'd0, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd1, 16'hF0F0, 4'd2, 16'h0FF0, 4'd2, 4'd7, 4'd1, 4'd2, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd3, 4'd7, 4'd1, 4'd2, 16'hFFF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd4, 4'd7, 4'd1, 4'd2, 16'hFF00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd1, 16'h8000, 4'd2, 16'h000F, 4'd6, 4'd7, 4'd1, 4'd2, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'd1, 16'h1234, 4'd2, 16'h1234, 4'd1, 4'd3, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) preload(4'(i), 16'(i * 16'h1111));
        mz = 1'b0;
        mc = 1'b0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_op = 4'd0; instr_rd = 4'd0; instr_rs0 = 4'd0; instr_rs1 = 4'd0;

        #3;
        chk("reset_outputs_a", 32'({instr_ready, rf_rd_en, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr0_addr}), 32'd0);
        chk("reset_outputs_b", 32'({rf_wr0_data, result_valid, op_err, flag_z, flag_c}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(instr_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].init) begin
                preload(vecs[i].ra, vecs[i].va);
                preload(vecs[i].rb, vecs[i].vb);
            end
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs0, vecs[i].rs1,
                      vecs[i].data, vecs[i].z, vecs[i].c, vecs[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) preload(4'($urandom_range(0, 15)), 16'($urandom));
            if ($urandom_range(0, 7) == 0) preload(4'($urandom_range(0, 15)), 16'h0000);
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            run_random(rop, 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // continuous valid: acceptances every 4 cycles
        while (!instr_ready) @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 4'd7; instr_rd = 4'd8; instr_rs0 = 4'd8; instr_rs1 = 4'd8;
        cnt = 0;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) begin
                if (last >= 0) chk("issue_interval", 32'(i - last), 32'd4);
                last = i;
                cnt++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("issue_count", 32'(cnt), 32'd3);
        chk("stream_flags", 32'({flag_z, flag_c}), 32'({mreg[8] == 16'h0, 1'b0}));
        mz = (mreg[8] == 16'h0);
        mc = 1'b0;

        // reset during EXEC discards the instruction
        preload(4'd1, 16'h0007);
        preload(4'd2, 16'h0007);
        preload(4'd3, 16'h1111);
        while (!instr_ready) @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 4'd0; instr_rd = 4'd3; instr_rs0 = 4'd1; instr_rs1 = 4'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs_a", 32'({instr_ready, rf_rd_en, rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr0_addr}), 32'd0);
        chk("midreset_outputs_b", 32'({rf_wr0_data, result_valid, op_err, flag_z, flag_c}), 32'd0);
        repeat (3) @(posedge clk);
        chk("midreset_no_write", 32'(rf_mem[3]), 32'h1111);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_midreset", 32'(instr_ready), 32'd1);
        mz = 1'b0;
        mc = 1'b0;
        run_instr(4'd0, 4'd3, 4'd1, 4'd2, 16'h000E, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
